// File: rtl/mont_mul_param.sv
// mont_mul_param
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// One iteration of the interleaved reduction is done per clock. A start/busy/done
// handshake lets a controller chain products, and use_prev feeds the held result
// back as operand A.
//
// Optional feature macro: MONT_FINAL_SUB_EN
//   defined   : adds a SUB state that applies the final conditional subtraction,
//               so result < M.
//   undefined : result is the raw accumulator (< 2M) and latency is one cycle shorter.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset; aborts any operation
//   start     in   request, sampled only in IDLE
//   use_prev  in   sampled with start; 1 selects A = result[WIDTH-1:0]
//   in_a      in   [WIDTH-1:0] operand A (A < M)
//   in_b      in   [WIDTH-1:0] operand B (B < M)
//   in_m      in   [WIDTH-1:0] odd modulus
//   result    out  [WIDTH:0]   product, held until the next completion
//   done      out  one-cycle pulse when result is updated
//   busy      out  high from the cycle after acceptance through the done cycle
//
// state | meaning
// IDLE  | waiting for start, busy low
// LOOP  | one reduction iteration per cycle, WIDTH cycles
// SUB   | final conditional subtraction (MONT_FINAL_SUB_EN only)
// DONE  | done pulse, returns to IDLE without sampling start
module mont_mul_param #(
  parameter int WIDTH = 512,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_prev,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOOP, SUB, DONE} stateT;

  localparam logic [CNT_W-1:0] lastIter = CNT_W'(WIDTH - 1);

  stateT            state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] mReg;
  logic [WIDTH:0]   accC;
  logic [CNT_W-1:0] iterCnt;

  logic             aBit;
  logic             qBit;
  logic [WIDTH+1:0] sumFull;
  logic [WIDTH:0]   accNext;

  // q is chosen so the pre-shift sum is even; the full WIDTH+2 bit sum is kept
  // so nothing is lost before the divide-by-two.
  always_comb begin
    aBit    = aReg[0];
    qBit    = accC[0] ^ (aBit & bReg[0]);
    sumFull = {1'b0, accC}
            + (aBit ? {2'b00, bReg} : '0)
            + (qBit ? {2'b00, mReg} : '0);
    accNext = (WIDTH+1)'(sumFull >> 1);
  end

`ifdef MONT_FINAL_SUB_EN
  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    diff   = {1'b0, accC} - {2'b00, mReg};
    borrow = diff[WIDTH+1];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      aReg    <= '0;
      bReg    <= '0;
      mReg    <= '0;
      accC    <= '0;
      iterCnt <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            aReg    <= use_prev ? result[WIDTH-1:0] : in_a;
            bReg    <= in_b;
            mReg    <= in_m;
            accC    <= '0;
            iterCnt <= '0;
            busy    <= 1'b1;
            state   <= LOOP;
          end
        end
        LOOP: begin
          accC    <= accNext;
          aReg    <= aReg >> 1;
          iterCnt <= iterCnt + CNT_W'(1);
          if (iterCnt == lastIter) begin
`ifdef MONT_FINAL_SUB_EN
            state <= SUB;
`else
            result <= accNext;
            done   <= 1'b1;
            state  <= DONE;
`endif
          end
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: begin
          result <= borrow ? accC : diff[WIDTH:0];
          done   <= 1'b1;
          state  <= DONE;
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_param.sv
// Self-checking bench for mont_mul_param at WIDTH=8.
// Expected products come from a modular-arithmetic reference (A*B mod M, then
// WIDTH modular halvings). A monitor pops the expected queue on every done pulse
// and checks value, latency and the busy window.
module tb_mont_mul_param;

  localparam int W = 8;
`ifdef MONT_FINAL_SUB_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif
  localparam int P    = LAT + 2;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         reset;
  logic         start;
  logic         use_prev;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_m;
  logic [W:0]   result;
  logic         done;
  logic         busy;

  mont_mul_param #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .use_prev (use_prev),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_m     (in_m),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] m;
    int           edge0;
    bit           chkVal;
  } expT;

  expT          sbq[$];
  int           cycle = 0;
  int           nVec = 0;
  int           miscompares = 0;
  int           busyStart = 0;
  int           busyEnd = 0;
  bit           monOn = 0;
  logic [W-1:0] prevVal = '0;
  logic [W-1:0] prevM = '0;
  bit           prevValid = 1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cycle);
    $fatal(1);
  end

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [W-1:0] montRef(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [2*W+1:0] x;
    logic [2*W+1:0] mw;
    mw = {{(W+2){1'b0}}, m};
    x  = ({{(W+2){1'b0}}, a} * {{(W+2){1'b0}}, b}) % mw;
    for (int i = 0; i < W; i++) x = x[0] ? (x + mw) >> 1 : x >> 1;
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] randM();
    return W'(($urandom_range(1, HALF - 1) << 1) | 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: busy window, done value and latency.
  always @(negedge clk) begin
    if (monOn) begin
      bit           expBusy;
      expT          e;
      logic [W+1:0] resW;
      logic [W+1:0] mW;
      expBusy = (cycle >= busyStart) && (cycle < busyEnd);
      chk("busy", busy == expBusy, busy, expBusy);
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1'b0, done, 0);
        end else begin
          e = sbq.pop_front();
          chk("latency", cycle == e.edge0 + LAT, cycle - e.edge0, LAT);
          if (e.chkVal) begin
            resW = {1'b0, result};
            mW   = {2'b00, e.m};
`ifdef MONT_FINAL_SUB_EN
            chk("result", result == {1'b0, e.res}, result, e.res);
`else
            chk("result", (resW < 2 * mW) && ((resW % mW) == {2'b00, e.res}), result, e.res);
`endif
          end
        end
      end else if (sbq.size() > 0 && cycle > sbq[0].edge0 + LAT) begin
        chk("missing_done", 1'b0, cycle - sbq[0].edge0, LAT);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic push(input logic [W-1:0] res, input logic [W-1:0] m, input bit chkVal);
    expT e;
    e.res    = res;
    e.m      = m;
    e.edge0  = cycle + 1;
    e.chkVal = chkVal;
    sbq.push_back(e);
    busyStart = e.edge0;
    busyEnd   = e.edge0 + LAT + 1;
    prevVal   = res;
    prevM     = m;
    prevValid = chkVal;
    nVec++;
  endtask

  task automatic waitIdle();
    int g = 0;
    tick();
    while (busy && g < 200) begin
      tick();
      g++;
    end
    chk("idle_timeout", g < 200, g, 200);
  endtask

  // Returns with cycle == edge0 of the accepted operation.
  task automatic issue(input bit useP, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] m, input bit chkVal);
    logic [W-1:0] aEff;
    waitIdle();
    aEff     = useP ? prevVal : a;
    start    = 1;
    use_prev = useP;
    in_a     = a;
    in_b     = b;
    in_m     = m;
    push(montRef(aEff, b, m), m, chkVal);
    tick();
    start    = 0;
    use_prev = 1'($urandom);
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_m     = W'($urandom);
  endtask

  task automatic heldStart();
    logic [W-1:0] a, b, m;
    waitIdle();
    start    = 1;
    use_prev = 0;
    for (int k = 0; k < 3; k++) begin
      m    = randM();
      a    = W'($urandom_range(0, int'(m) - 1));
      b    = W'($urandom_range(0, int'(m) - 1));
      in_a = a;
      in_b = b;
      in_m = m;
      push(montRef(a, b, m), m, 1);
      if (k < 2) repeat (P) tick();
    end
    tick();
    start = 0;
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() > 0 && g < 4 * P) begin
      tick();
      g++;
    end
    chk("drain_timeout", sbq.size() == 0, sbq.size(), 0);
  endtask

  initial begin
    logic [W-1:0] m;
    reset    = 1;
    start    = 0;
    use_prev = 0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;
    repeat (3) tick();
    chk("rst_result", result == '0, result, 0);
    chk("rst_busy", busy == 1'b0, busy, 0);
    chk("rst_done", done == 1'b0, done, 0);
    reset = 0;
    monOn = 1;

    issue(0, 8'd5, 8'd7, 8'd13, 1);
    issue(1, 8'd0, 8'd9, 8'd13, 1);
    issue(0, 8'd0, 8'd12, 8'd13, 1);
    issue(0, 8'd12, 8'd12, 8'd13, 1);
    issue(1, 8'd0, 8'd3, 8'd13, 1);
    issue(0, 8'd5, 8'd7, 8'd12, 0);
    issue(0, 8'd255, 8'd255, 8'd255, 1);
    drain();

    // Reset mid-operation: sampled at edge 4 of the run.
    m = 8'd97;
    issue(0, 8'd40, 8'd77, m, 1);
    repeat (3) tick();
    reset   = 1;
    busyEnd = cycle + 1;
    sbq.delete();
    tick();
    chk("midrst_busy", busy == 1'b0, busy, 0);
    chk("midrst_result", result == '0, result, 0);
    chk("midrst_done", done == 1'b0, done, 0);
    reset     = 0;
    prevVal   = '0;
    prevM     = m;
    prevValid = 1;
    issue(1, 8'd55, 8'd66, m, 1);
    issue(0, 8'd40, 8'd77, m, 1);
    drain();

    heldStart();
    drain();

    for (int i = 0; i < 150; i++) begin
      if (prevValid && int'(prevM) < HALF && $urandom_range(0, 3) == 0) begin
        issue(1, W'($urandom), W'($urandom_range(0, int'(prevM) - 1)), prevM, 1);
      end else begin
        m = randM();
        issue(0, W'($urandom_range(0, int'(m) - 1)), W'($urandom_range(0, int'(m) - 1)), m, 1);
      end
      if ($urandom_range(0, 4) == 0) begin
        tick();
        start    = 1;
        use_prev = 1'($urandom);
        in_a     = W'($urandom);
        tick();
        start = 0;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    repeat (P) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, miscompares);
    $finish;
  end

endmodule
